div_iter: RTL and testbench
===========================

Name: div_iter

Overview:
- Multi-cycle signed 32-bit integer divider for the multdiv unit.
- Takes the inverse path to the multiplier and performs restoring division: one shift/trial-subtract step per cycle.
- Shares the controller handshake used by the multiplier: start pulse in, one-cycle ready pulse out.
- Quotient truncates toward zero.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; low forces IDLE immediately.
- ctrl_DIV  input  1  start pulse; samples operands on the same edge.
- data_operandA  input  WIDTH  dividend, two's complement.
- data_operandB  input  WIDTH  divisor, two's complement.
- data_result  output  WIDTH  signed quotient; held until next start.
- data_exception  output  1  divide-by-zero flag; valid with data_resultRDY, held with result.
- data_resultRDY  output  1  one-cycle pulse when data_result/data_exception become valid.
- busy  output  1  high while a division is in progress.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; data_result=0, data_exception=0, data_resultRDY=0, busy=0; internal quotient, remainder, divisor and counter registers are cleared. Reset mid-operation abandons the operation with no ready pulse.
- States: IDLE, RUN, DONE.
- IDLE: busy=0. On a ctrl_DIV edge:
  - Latch |A| and |B| as unsigned WIDTH-bit magnitudes; |0x80000000| = 0x80000000.
  - Latch sign flags sq = A[msb] XOR B[msb] and sr = A[msb].
  - Clear the remainder and set counter=0.
  - If B==0, go to DONE with the exception pending; otherwise go to RUN.
- RUN: busy=1. Each cycle:
  - rem = {rem[WIDTH-2:0], quot[msb]}, quot <<= 1.
  - Trial = rem − |B| over WIDTH+1 bits. If non-negative, rem = trial and quot[0] = 1.
  - counter++. After WIDTH iterations, go to DONE.
- DONE: single cycle.
  - data_result = sq ? −quot : quot (two's complement, WIDTH bits). On divide-by-zero, data_result=0 and data_exception=1; otherwise data_exception=0.
  - data_resultRDY=1 for exactly this cycle, busy=0, then go to IDLE.
- Latency, with ctrl_DIV sampled at edge 0:
  - Normal case: data_resultRDY is high in the cycle after edge WIDTH+1, i.e. WIDTH+1 edges after the start.
  - Divide-by-zero: data_resultRDY is high after edge 1.
- Outputs hold their last value in IDLE until the next DONE.
- ctrl_DIV while busy (RUN): abort the current operation with no ready pulse, relatch operands, and restart from iteration 0 on the same edge.
- ctrl_DIV in DONE: the ready pulse for the finishing operation still fires; the new operation starts (relatch) on that same edge and goes to RUN, not IDLE.
- Overflow 0x80000000 / 0xFFFFFFFF: the magnitude quotient 0x80000000 is not negated (signs equal), so data_result=0x80000000 with data_exception=0. This wrap is documented, not flagged.
- Operands are don't-care except on ctrl_DIV edges.

Optional Feature:
- Macro: DIV_REMAINDER_EN.
- Defined:
  - Adds output port data_remainder (WIDTH) = sr ? −rem : rem, so the sign follows the dividend.
  - Updated in DONE and held in IDLE; resets to 0; 0 on divide-by-zero.
  - Invariant: A == result*B + remainder.
- Undefined: the port is absent, and no remainder sign-correction logic is generated.

Test Plan:
- A=100, B=7, ctrl_DIV pulse → data_resultRDY pulses once, 33 edges later; data_result=14 (0x0000000E), data_exception=0; with DIV_REMAINDER_EN, data_remainder=2.
- A=−100 (0xFFFFFF9C), B=7 → data_result=0xFFFFFFF2 (−14); remainder=0xFFFFFFFE (−2). Then A=100, B=−7 → data_result=−14 and remainder=+2.
- A=5, B=0 → data_resultRDY after 1 edge; data_exception=1, data_result=0; next start with A=9, B=3 → data_exception=0, data_result=3.
- A=0x80000000, B=0xFFFFFFFF → data_result=0x80000000, data_exception=0. A=0x80000000, B=1 → 0x80000000. A=0, B=−5 → 0.
- Start A=1000, B=10; at iteration 12, pulse ctrl_DIV with A=50, B=5 → no ready pulse for the first operation; a single pulse 33 edges after the restart with data_result=10.
- Start A=77, B=7; drive reset low for half a cycle at iteration 20 → all outputs 0 immediately, busy=0, no ready pulse. After release, A=77, B=7 → data_result=11.

Source files
------------

// File: rtl/div_iter.sv
// div_iter: signed restoring divider, one quotient bit per cycle, start-pulse / ready-pulse handshake.
// Optional macro DIV_REMAINDER_EN adds data_remainder, whose sign follows the dividend.
module div_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
`ifdef DIV_REMAINDER_EN
   output logic [WIDTH-1:0] data_remainder,
`endif
   output logic             busy
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] divs_q, divs_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             sq_q, sq_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             exc_q, exc_d;
   logic             rdy_q, rdy_d;
`ifdef DIV_REMAINDER_EN
   logic             sr_q, sr_d;
   logic [WIDTH-1:0] remout_q, remout_d;
`endif

   logic [WIDTH-1:0] mag_a, mag_b, rem_sh;
   logic [WIDTH:0]   trial;

   always_comb begin
      state_d  = state_q;
      quot_d   = quot_q;
      rem_d    = rem_q;
      divs_d   = divs_q;
      cnt_d    = cnt_q;
      sq_d     = sq_q;
      dz_d     = dz_q;
      result_d = result_q;
      exc_d    = exc_q;
      rdy_d    = 1'b0;
`ifdef DIV_REMAINDER_EN
      sr_d     = sr_q;
      remout_d = remout_q;
`endif
      mag_a  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
      mag_b  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
      rem_sh = {rem_q[WIDTH-2:0], quot_q[WIDTH-1]};
      // Borrow out of the extra top bit means the trial subtraction went negative.
      trial  = {1'b0, rem_sh} - {1'b0, divs_q};

      case (state_q)
         StRun: begin
            quot_d = {quot_q[WIDTH-2:0], ~trial[WIDTH]};
            rem_d  = trial[WIDTH] ? rem_sh : trial[WIDTH-1:0];
            cnt_d  = cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            rdy_d    = 1'b1;
            exc_d    = dz_q;
            result_d = dz_q ? '0 : (sq_q ? -quot_q : quot_q);
`ifdef DIV_REMAINDER_EN
            remout_d = dz_q ? '0 : (sr_q ? -rem_q : rem_q);
`endif
            state_d  = StIdle;
         end
         default: ;
      endcase

      // A start in any state relatches and restarts; DONE still publishes above.
      if (ctrl_DIV) begin
         quot_d  = mag_a;
         divs_d  = mag_b;
         rem_d   = '0;
         cnt_d   = '0;
         sq_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         dz_d    = (data_operandB == '0);
`ifdef DIV_REMAINDER_EN
         sr_d    = data_operandA[WIDTH-1];
`endif
         state_d = (data_operandB == '0) ? StDone : StRun;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         quot_q   <= '0;
         rem_q    <= '0;
         divs_q   <= '0;
         cnt_q    <= '0;
         sq_q     <= 1'b0;
         dz_q     <= 1'b0;
         result_q <= '0;
         exc_q    <= 1'b0;
         rdy_q    <= 1'b0;
`ifdef DIV_REMAINDER_EN
         sr_q     <= 1'b0;
         remout_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         quot_q   <= quot_d;
         rem_q    <= rem_d;
         divs_q   <= divs_d;
         cnt_q    <= cnt_d;
         sq_q     <= sq_d;
         dz_q     <= dz_d;
         result_q <= result_d;
         exc_q    <= exc_d;
         rdy_q    <= rdy_d;
`ifdef DIV_REMAINDER_EN
         sr_q     <= sr_d;
         remout_q <= remout_d;
`endif
      end
   end

   assign data_result    = result_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;
   assign busy           = (state_q == StRun);
`ifdef DIV_REMAINDER_EN
   assign data_remainder = remout_q;
`endif

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: directed cases plus random operands, checked against integer-arithmetic model.
module tb_div_iter;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;
`ifdef DIV_REMAINDER_EN
   logic [31:0] data_remainder;
`endif

   int tests = 0;
   int fails = 0;

   div_iter #(.WIDTH(32)) dut (
      .clock         (clock),
      .reset         (reset),
      .ctrl_DIV      (ctrl_DIV),
      .data_operandA (a),
      .data_operandB (b),
      .data_result   (data_result),
      .data_exception(data_exception),
      .data_resultRDY(data_resultRDY),
`ifdef DIV_REMAINDER_EN
      .data_remainder(data_remainder),
`endif
      .busy          (busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Truncating signed division; the one overflow case wraps to the dividend.
   function automatic logic [31:0] ref_q(input logic [31:0] x, input logic [31:0] y);
      int xi = x;
      int yi = y;
      if (y == 32'd0) return 32'd0;
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
      return 32'(xi / yi);
   endfunction

   function automatic logic [31:0] ref_r(input logic [31:0] x, input logic [31:0] y);
      int xi = x;
      int yi = y;
      if (y == 32'd0) return 32'd0;
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
      return 32'(xi % yi);
   endfunction

   // Called just after a negedge; returns just after the negedge following the start edge.
   task automatic issue(input logic [31:0] x, input logic [31:0] y);
      a = x;
      b = y;
      ctrl_DIV = 1'b1;
      @(negedge clock);
      ctrl_DIV = 1'b0;
      a = $urandom;
      b = $urandom;
   endtask

   task automatic measure(input string tag, input logic [31:0] x, input logic [31:0] y);
      int lat = 0;
      int pulses = 0;
      logic [31:0] res = '0;
      logic [31:0] rm = '0;
      logic exc = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clock);
         if (n == 5 && y != 32'd0) check({tag, " busy mid-run"}, 32'(busy), 32'd1);
         if (data_resultRDY) begin
            pulses++;
            if (lat == 0) begin
               lat = n;
               res = data_result;
               exc = data_exception;
`ifdef DIV_REMAINDER_EN
               rm  = data_remainder;
`endif
            end
         end
      end
      check({tag, " latency"}, 32'(lat), (y == 32'd0) ? 32'd1 : 32'd33);
      check({tag, " pulses"}, 32'(pulses), 32'd1);
      check({tag, " result"}, res, ref_q(x, y));
      check({tag, " exception"}, 32'(exc), (y == 32'd0) ? 32'd1 : 32'd0);
      check({tag, " result held"}, data_result, ref_q(x, y));
      check({tag, " busy idle"}, 32'(busy), 32'd0);
`ifdef DIV_REMAINDER_EN
      check({tag, " remainder"}, rm, ref_r(x, y));
`else
      check({tag, " remainder unused"}, rm, 32'd0);
`endif
   endtask

   task automatic run_div(input string tag, input logic [31:0] x, input logic [31:0] y);
      issue(x, y);
      measure(tag, x, y);
   endtask

   initial begin
      int early;
      logic [31:0] x;
      logic [31:0] y;

      #1;
      check("reset result", data_result, 32'd0);
      check("reset exception", 32'(data_exception), 32'd0);
      check("reset ready", 32'(data_resultRDY), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      run_div("100/7", 32'd100, 32'd7);
      run_div("-100/7", 32'hFFFF_FF9C, 32'd7);
      run_div("100/-7", 32'd100, 32'hFFFF_FFF9);
      run_div("5/0", 32'd5, 32'd0);
      run_div("9/3", 32'd9, 32'd3);
      run_div("min/-1", 32'h8000_0000, 32'hFFFF_FFFF);
      run_div("min/1", 32'h8000_0000, 32'd1);
      run_div("0/-5", 32'd0, 32'hFFFF_FFFB);
      run_div("max/min", 32'h7FFF_FFFF, 32'h8000_0000);

      // Restart mid-run: first operation must never report.
      early = 0;
      issue(32'd1000, 32'd10);
      for (int n = 1; n <= 12; n++) begin
         @(negedge clock);
         if (data_resultRDY) early++;
      end
      check("abort no early pulse", 32'(early), 32'd0);
      run_div("restart 50/5", 32'd50, 32'd5);

      // Asynchronous reset mid-run clears outputs at once and suppresses the pulse.
      issue(32'd77, 32'd7);
      for (int n = 1; n <= 20; n++) @(negedge clock);
      reset = 1'b0;
      #1;
      check("async rst result", data_result, 32'd0);
      check("async rst exception", 32'(data_exception), 32'd0);
      check("async rst ready", 32'(data_resultRDY), 32'd0);
      check("async rst busy", 32'(busy), 32'd0);
`ifdef DIV_REMAINDER_EN
      check("async rst remainder", data_remainder, 32'd0);
`endif
      #3;
      reset = 1'b1;
      early = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clock);
         if (data_resultRDY || busy) early++;
      end
      check("after rst quiet", 32'(early), 32'd0);
      run_div("77/7", 32'd77, 32'd7);

      // Start landing in DONE: old result still published, new one follows.
      early = 0;
      issue(32'd200, 32'd9);
      for (int n = 1; n <= 32; n++) begin
         @(negedge clock);
         if (data_resultRDY) early++;
      end
      check("overlap no early pulse", 32'(early), 32'd0);
      issue(32'd300, 32'hFFFF_FFF9);
      check("overlap first ready", 32'(data_resultRDY), 32'd1);
      check("overlap first result", data_result, ref_q(32'd200, 32'd9));
      check("overlap restarted busy", 32'(busy), 32'd1);
      measure("overlap 300/-7", 32'd300, 32'hFFFF_FFF9);

      for (int i = 0; i < 20; i++) begin
         x = $urandom;
         case (i % 5)
            0:       y = 32'd0;
            1:       y = 32'($urandom_range(1, 15));
            2:       y = -32'($urandom_range(1, 15));
            3:       y = $urandom >> $urandom_range(0, 31);
            default: y = $urandom;
         endcase
         if (i % 7 == 6) x = x >> 20;
         run_div($sformatf("rand%0d", i), x, y);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
